// File: rtl/ysyx_25030093_csr_file.sv
// rtl/ysyx_25030093_csr_file.sv - M-mode CSR file with trap/MRET redirect FSM; mcycle counter under CSR_MCYCLE_EN
`timescale 1ns/1ps
module ysyx_25030093_csr_file #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     HART_ID   = 0,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wsrc,
    input  logic            csr_wsrc_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    output logic            req_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
`endif
    localparam logic [1:0]      MXL      = (XLEN == 64) ? 2'd2 : 2'd1;
    localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-28){1'b0}}, 26'h100};

    typedef enum logic {S_IDLE, S_REDIR} state_t;
    state_t state;

    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
`ifdef CSR_MCYCLE_EN
    logic [63:0]     mcycle;
`endif
    logic            impl, ro, is_write, csr_we;
    logic            trap_acc, mret_acc;
    logic [XLEN-1:0] wdata, vec_base, trap_target;

    // Address decode and combinational read mux; unimplemented addresses read 0
    always_comb begin
        impl      = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS: begin
                csr_rdata[12:11] = 2'b11;
                csr_rdata[7]     = mpie;
                csr_rdata[3]     = mie;
            end
            A_MISA:     csr_rdata = MISA_VAL;
            A_MTVEC:    csr_rdata = mtvec & ~XLEN'(2);
            A_MSCRATCH: csr_rdata = mscratch;
            A_MEPC:     csr_rdata = mepc;
            A_MCAUSE:   csr_rdata = mcause;
            A_MTVAL:    csr_rdata = mtval;
            A_MHARTID:  csr_rdata = XLEN'(HART_ID);
`ifdef CSR_MCYCLE_EN
            A_MCYCLE:   csr_rdata = mcycle[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) csr_rdata = XLEN'(mcycle[63:32]);
                else            impl = 1'b0;
            end
`endif
            default:    impl = 1'b0;
        endcase
    end

    // Legality, read-modify-write value and trap vector computation
    always_comb begin
        ro          = (csr_addr[11:10] == 2'b11) || (csr_addr == A_MISA);
        is_write    = (csr_op == 2'b01) || (csr_op[1] && !csr_wsrc_zero);
        csr_illegal = (csr_op != 2'b00) && (!impl || (is_write && ro));
        csr_we      = is_write && !csr_illegal;
        case (csr_op)
            2'b01:   wdata = csr_wsrc;
            2'b10:   wdata = csr_rdata | csr_wsrc;
            2'b11:   wdata = csr_rdata & ~csr_wsrc;
            default: wdata = csr_rdata;
        endcase
        trap_acc    = trap_valid && req_ready;
        mret_acc    = mret_valid && req_ready && !trap_valid;
        vec_base    = {mtvec[XLEN-1:2], 2'b00};
        trap_target = (mtvec[0] && trap_cause[XLEN-1])
                    ? vec_base + {trap_cause[XLEN-3:0], 2'b00} : vec_base;
    end

    // Redirect FSM: IDLE accepts one trap/MRET, REDIR emits the one-cycle redirect pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            req_ready      <= 1'b1;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trap_acc) begin
                        state          <= S_REDIR;
                        req_ready      <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= trap_target;
                    end else if (mret_acc) begin
                        state          <= S_REDIR;
                        req_ready      <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= mepc;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    req_ready      <= 1'b1;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    // Trap-visible CSRs: trap and MRET take priority over a software write to the same register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else if (trap_acc) begin
            mepc   <= trap_pc & ~XLEN'(3);
            mcause <= trap_cause;
            mtval  <= trap_tval;
            mpie   <= mie;
            mie    <= 1'b0;
        end else begin
            if (mret_acc) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (csr_we && csr_addr == A_MSTATUS) begin
                mie  <= wdata[3];
                mpie <= wdata[7];
            end
            if (csr_we && csr_addr == A_MEPC)   mepc   <= wdata & ~XLEN'(3);
            if (csr_we && csr_addr == A_MCAUSE) mcause <= wdata;
            if (csr_we && csr_addr == A_MTVAL)  mtval  <= wdata;
        end
    end

    // Software-only CSRs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
        end else begin
            if (csr_we && csr_addr == A_MTVEC)    mtvec    <= wdata;
            if (csr_we && csr_addr == A_MSCRATCH) mscratch <= wdata;
        end
    end

`ifdef CSR_MCYCLE_EN
    // Free-running cycle counter; a software write to one half freezes the other half that cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                 mcycle <= '0;
        else if (csr_we && csr_addr == A_MCYCLE)  mcycle[XLEN-1:0] <= wdata;
        else if (csr_we && csr_addr == A_MCYCLEH) mcycle[63:32] <= wdata[31:0];
        else                                      mcycle <= mcycle + 64'd1;
    end
`endif
endmodule

// File: tb/tb_ysyx_25030093_csr_file.sv
// tb/tb_ysyx_25030093_csr_file.sv - randomized bench for ysyx_25030093_csr_file with behavioural model
`timescale 1ns/1ps
module tb_ysyx_25030093_csr_file;
    localparam logic [31:0] MTVEC_INIT = 32'h0000_0103;
    localparam int unsigned HART       = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wsrc = '0;
    logic        csr_wsrc_zero = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
    logic        mret_valid = 1'b0;
    logic        req_ready, redirect_valid;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_25030093_csr_file #(.XLEN(32), .HART_ID(HART), .MTVEC_RST(MTVEC_INIT)) dut (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wsrc(csr_wsrc),
        .csr_wsrc_zero(csr_wsrc_zero), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .req_ready(req_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Behavioural machine state
    bit          m_mie, m_mpie, m_busy;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
    logic [63:0] m_cycle;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void mread(input logic [11:0] a, output logic [31:0] v, output bit impl, output bit ro);
        impl = 1'b1;
        ro   = (a >= 12'hC00);
        v    = '0;
        case (a)
            12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h301: begin v = 32'h4000_0100; ro = 1'b1; end
            12'h305: v = m_mtvec & 32'hFFFF_FFFD;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'hF14: v = HART;
`ifdef CSR_MCYCLE_EN
            12'hB00: v = m_cycle[31:0];
            12'hB80: v = m_cycle[63:32];
`endif
            default: impl = 1'b0;
        endcase
    endfunction

    function automatic bit m_ill(input logic [11:0] a, input logic [1:0] op, input bit z);
        logic [31:0] v;
        bit impl, ro, wr;
        mread(a, v, impl, ro);
        wr = (op == 2'd1) || (op >= 2'd2 && !z);
        return (op != 2'd0) && (!impl || (wr && ro));
    endfunction

    // Model advances once per clock from the inputs presented in that cycle
    logic [31:0] s_old, s_nv, s_tgt, s_oldepc;
    bit          s_impl, s_ro, s_wr, s_ill, s_trap, s_mret;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mie = 0; m_mpie = 0; m_busy = 0; m_rpc = 0;
            m_mtvec = MTVEC_INIT; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_cycle = 0;
        end else begin
            mread(csr_addr, s_old, s_impl, s_ro);
            s_wr  = (csr_op == 2'd1) || (csr_op >= 2'd2 && !csr_wsrc_zero);
            s_ill = m_ill(csr_addr, csr_op, csr_wsrc_zero);
            case (csr_op)
                2'd1:    s_nv = csr_wsrc;
                2'd2:    s_nv = s_old | csr_wsrc;
                2'd3:    s_nv = s_old & ~csr_wsrc;
                default: s_nv = s_old;
            endcase
            s_trap   = !m_busy && trap_valid;
            s_mret   = !m_busy && mret_valid && !trap_valid;
            s_oldepc = m_mepc;
            s_tgt    = m_mtvec - (m_mtvec % 4);
            if (m_mtvec[0] && trap_cause[31]) s_tgt = s_tgt + trap_cause[30:0] * 4;
            m_cycle = m_cycle + 1;
            if (s_wr && !s_ill) begin
                case (csr_addr)
                    12'h300: if (!s_trap && !s_mret) begin m_mie = s_nv[3]; m_mpie = s_nv[7]; end
                    12'h305: m_mtvec = s_nv;
                    12'h340: m_mscratch = s_nv;
                    12'h341: if (!s_trap) m_mepc = s_nv & 32'hFFFF_FFFC;
                    12'h342: if (!s_trap) m_mcause = s_nv;
                    12'h343: if (!s_trap) m_mtval = s_nv;
                    12'hB00: m_cycle = {m_cycle[63:32] - ((m_cycle[31:0] == 0) ? 32'd1 : 32'd0), s_nv};
                    12'hB80: m_cycle = {s_nv, m_cycle[31:0] - 32'd1};
                    default: ;
                endcase
            end
            if (m_busy) m_busy = 0;
            else if (s_trap) begin
                m_mepc = trap_pc & 32'hFFFF_FFFC; m_mcause = trap_cause; m_mtval = trap_tval;
                m_mpie = m_mie; m_mie = 0;
                m_busy = 1; m_rpc = s_tgt;
            end else if (s_mret) begin
                m_mie = m_mpie; m_mpie = 1;
                m_busy = 1; m_rpc = s_oldepc;
            end
        end
    end

    // Every-cycle comparison against the model
    logic [31:0] c_v;
    bit          c_impl, c_ro;
    always @(negedge clk) begin
        mread(csr_addr, c_v, c_impl, c_ro);
        chk("rdata", 64'(csr_rdata), 64'(c_v));
        chk("illegal", 64'(csr_illegal), 64'(m_ill(csr_addr, csr_op, csr_wsrc_zero)));
        chk("req_ready", 64'(req_ready), 64'(!m_busy));
        chk("redirect_valid", 64'(redirect_valid), 64'(m_busy));
        if (m_busy) chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_op = 0; csr_wsrc = 0; csr_wsrc_zero = 0; trap_valid = 0; mret_valid = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v, input bit z);
        csr_addr = a; csr_op = op; csr_wsrc = v; csr_wsrc_zero = z;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        csr_addr = a; csr_op = 0; csr_wsrc_zero = 0;
        #1;
        chk(nm, 64'(csr_rdata), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    localparam int NADDR = 14;
    logic [11:0] addr_tab [NADDR] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                      12'hF14, 12'hB00, 12'hB80, 12'h000, 12'h344, 12'hC00, 12'h7C0};

    initial begin
        idle();
        repeat (3) cyc();
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset redirect_valid", 64'(redirect_valid), 64'd0);
        rst = 1'b1;
        rd(12'h300, 32'h0000_1800, "reset mstatus");
        rd(12'h305, 32'h0000_0101, "reset mtvec");
        chk("reset redirect_pc", 64'(redirect_pc), 64'd0);

        wr(12'h300, 2'd2, 32'h88, 0); cyc(); rd(12'h300, 32'h1888, "mstatus RS");
        wr(12'h300, 2'd3, 32'h08, 0); cyc(); rd(12'h300, 32'h1880, "mstatus RC");
        wr(12'h300, 2'd2, 32'h00, 1); #1;
        chk("RS zero legal", 64'(csr_illegal), 64'd0);
        cyc(); rd(12'h300, 32'h1880, "mstatus RS zero");
        wr(12'h300, 2'd2, 32'h08, 0); cyc(); rd(12'h300, 32'h1888, "mstatus MIE set");

        wr(12'h305, 2'd1, 32'h8000_0001, 0); cyc(); idle();
        trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h8000_0100; trap_tval = 32'h1234;
        #1; chk("trap ready", 64'(req_ready), 64'd1);
        cyc(); trap_valid = 0;
        chk("trap redirect_valid", 64'(redirect_valid), 64'd1);
        chk("trap vectored pc", 64'(redirect_pc), 64'h8000_001C);
        rd(12'h341, 32'h8000_0100, "trap mepc");
        rd(12'h342, 32'h8000_0007, "trap mcause");
        rd(12'h343, 32'h0000_1234, "trap mtval");
        cyc();
        chk("redirect one cycle", 64'(redirect_valid), 64'd0);
        rd(12'h300, 32'h1880, "trap mstatus");

        mret_valid = 1; cyc(); mret_valid = 0;
        chk("mret redirect_pc", 64'(redirect_pc), 64'h8000_0100);
        chk("mret redirect_valid", 64'(redirect_valid), 64'd1);
        rd(12'h300, 32'h1888, "mret mstatus");
        cyc();

        trap_valid = 1; mret_valid = 1; trap_cause = 32'h2; trap_pc = 32'h8000_0200;
        wr(12'h341, 2'd1, 32'hDEAD_0000, 0);
        cyc(); idle(); trap_valid = 1; trap_pc = 32'h8000_0300;
        chk("prio redirect_pc", 64'(redirect_pc), 64'h8000_0000);
        chk("prio ready low", 64'(req_ready), 64'd0);
        rd(12'h341, 32'h8000_0200, "prio mepc");
        cyc();
        chk("b2b gap", 64'(redirect_valid), 64'd0);
        chk("b2b ready", 64'(req_ready), 64'd1);
        cyc(); trap_valid = 0;
        chk("b2b second redirect", 64'(redirect_valid), 64'd1);
        rd(12'h341, 32'h8000_0300, "b2b mepc");
        rd(12'h300, 32'h1800, "b2b mstatus");
        cyc();

        wr(12'hF14, 2'd1, 32'hFF, 0); #1;
        chk("mhartid write illegal", 64'(csr_illegal), 64'd1);
        cyc(); rd(12'hF14, HART, "mhartid");
        wr(12'h301, 2'd2, 32'h0, 1); #1;
        chk("misa RS zero legal", 64'(csr_illegal), 64'd0);
        chk("misa value", 64'(csr_rdata), 64'h4000_0100);
        wr(12'h7C0, 2'd2, 32'h1, 0); #1;
        chk("unimpl illegal", 64'(csr_illegal), 64'd1);
        chk("unimpl rdata", 64'(csr_rdata), 64'd0);
        cyc();

`ifdef CSR_MCYCLE_EN
        wr(12'hB00, 2'd1, 32'hFFFF_FFFF, 0); cyc();
        wr(12'hB80, 2'd1, 32'h0, 0); cyc();
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle held");
        rd(12'hB80, 32'h0, "mcycleh written");
        cyc();
        rd(12'hB80, 32'h1, "mcycleh carry");
        rd(12'hB00, 32'h0, "mcycle wrap");
`else
        wr(12'hB00, 2'd2, 32'h0, 1); #1;
        chk("mcycle absent illegal", 64'(csr_illegal), 64'd1);
        chk("mcycle absent rdata", 64'(csr_rdata), 64'd0);
`endif
        cyc();

        idle(); trap_valid = 1; trap_cause = 32'h3; trap_pc = 32'h100;
        cyc(); trap_valid = 0;
        chk("pre-reset redirect", 64'(redirect_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async redirect drop", 64'(redirect_valid), 64'd0);
        chk("async ready", 64'(req_ready), 64'd1);
        cyc(); cyc(); rst = 1'b1;
        rd(12'h300, 32'h1800, "post-reset mstatus");
        rd(12'h305, 32'h101, "post-reset mtvec");
        rd(12'h341, 32'h0, "post-reset mepc");

        for (int i = 0; i < 3000; i++) begin
            cyc();
            csr_addr      = addr_tab[$urandom_range(0, NADDR-1)];
            csr_op        = 2'($urandom_range(0, 3));
            csr_wsrc_zero = ($urandom_range(0, 3) == 0);
            csr_wsrc      = csr_wsrc_zero ? 32'h0 : $urandom;
            trap_valid    = ($urandom_range(0, 7) == 0);
            trap_cause    = {1'($urandom_range(0, 1)), 27'h0, 4'($urandom_range(0, 15))};
            trap_pc       = $urandom;
            trap_tval     = $urandom;
            mret_valid    = ($urandom_range(0, 7) == 0);
        end
        cyc(); idle(); cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
